// File: rtl/cr_tie_seq_pkg.sv
// cr_tie_seq_pkg -- shared types and constants for the lane tie/release sequencer.
// Holds the sequencer state enum, the default parameter values and the legal
// parameter ranges used by cr_tie_seq and its gap counter.

package cr_tie_seq_pkg;

    // Sequencer states:
    //   ST_TIED   all lanes tied low, waiting for up_req
    //   ST_UP     releasing lanes from lane 0 upward
    //   ST_ACTIVE all lanes released, waiting for dn_req
    //   ST_DOWN   re-tying lanes from the highest released lane downward
    typedef enum logic [1:0] {
        ST_TIED   = 2'd0,
        ST_UP     = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DOWN   = 2'd3
    } state_e;

    // Default parameter values.
    localparam int N_LANES_DEF = 8;
    localparam int GAP_W_DEF   = 8;

    // Legal parameter ranges.
    localparam int N_LANES_MIN = 1;
    localparam int N_LANES_MAX = 32;
    localparam int GAP_W_MIN   = 1;
    localparam int GAP_W_MAX   = 16;

    // True when both parameters lie inside their legal ranges.
    function automatic bit params_legal(input int n_lanes, input int gap_w);
        return (n_lanes >= N_LANES_MIN) && (n_lanes <= N_LANES_MAX) &&
               (gap_w >= GAP_W_MIN) && (gap_w <= GAP_W_MAX);
    endfunction

endpackage

// File: rtl/cr_tie_seq_gap_cnt.sv
// cr_tie_seq_gap_cnt -- loadable GAP_W-bit down-counter that paces the lane
// transitions. tc_o is high while the count is zero, which marks a lane
// transition point. The counter saturates at zero, so it never wraps.

module cr_tie_seq_gap_cnt
    import cr_tie_seq_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [GAP_W-1:0] cnt_q;
    logic [GAP_W-1:0] cnt_d;

    // Next count: clear beats load, load beats decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cr_tie_seq.sv
// cr_tie_seq -- lane tie/release sequencer.
// On up_req the lane enables are released one at a time from lane 0 upward,
// spaced by gap_q+1 cycles. On dn_req they are re-tied from the top lane down
// with the same spacing. A dn_req seen while releasing aborts the release at
// the next transition point and turns it into a re-tie.
// lane_en is always a contiguous low-order mask.
//
// Optional feature: define CR_TIE_SEQ_FORCE_EN to add the force_tie input,
// which ties every lane low at the next edge and returns to TIED.
//
// Handshake: up_req and dn_req are level requests. They are sampled on every
// rising edge and take effect only in the states that accept them. No
// acknowledge is returned; busy, up_done and dn_done report progress.
//
// state_dbg exposes the FSM state for checkers.

module cr_tie_seq
    import cr_tie_seq_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int GAP_W   = GAP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CR_TIE_SEQ_FORCE_EN
    input  logic               force_tie,
`endif
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic               up_req,
    input  logic               dn_req,
    output logic [N_LANES-1:0] lane_en,
    output logic               busy,
    output logic               up_done,
    output logic               dn_done,
    output state_e             state_dbg
);

    localparam logic [N_LANES-1:0] LANE_ONE = N_LANES'(1);

    state_e             state_q;
    logic [N_LANES-1:0] lane_en_q;
    logic               busy_q;
    logic               up_done_q;
    logic               dn_done_q;
    logic [GAP_W-1:0]   gap_q;
    logic               abort_q;

    logic               force_w;
    logic               cnt_clr;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_tc;
    logic [N_LANES-1:0] lane_up;
    logic [N_LANES-1:0] lane_dn;

`ifdef CR_TIE_SEQ_FORCE_EN
    assign force_w = force_tie;
`else
    assign force_w = 1'b0;
`endif

    // Candidate masks: one more lane released, or the top lane re-tied.
    // Both keep the mask contiguous from lane 0.
    assign lane_up = (lane_en_q << 1) | LANE_ONE;
    assign lane_dn = lane_en_q >> 1;

    // Counter control: clear on request acceptance so the first transition
    // lands one cycle later; reload gap_q at every transition point.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (force_w) begin
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_TIED:   cnt_clr = up_req;
                ST_ACTIVE: cnt_clr = dn_req;
                ST_UP, ST_DOWN: begin
                    if (cnt_tc) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    cr_tie_seq_gap_cnt #(
        .GAP_W (GAP_W)
    ) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (gap_q),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    // Sequencer FSM with registered lane enables, busy and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_TIED;
            lane_en_q <= '0;
            busy_q    <= 1'b0;
            up_done_q <= 1'b0;
            dn_done_q <= 1'b0;
            gap_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            up_done_q <= 1'b0;
            dn_done_q <= 1'b0;
            if (force_w) begin
                state_q   <= ST_TIED;
                lane_en_q <= '0;
                busy_q    <= 1'b0;
                abort_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_TIED: begin
                        // up_req wins over a simultaneous dn_req; dn_req
                        // alone is ignored here.
                        if (up_req) begin
                            state_q <= ST_UP;
                            busy_q  <= 1'b1;
                            gap_q   <= cfg_gap;
                            abort_q <= 1'b0;
                        end
                    end
                    ST_UP: begin
                        if (cnt_tc) begin
                            if (abort_q || dn_req) begin
                                // Abort: re-tie the top lane instead of
                                // releasing the next one. With nothing
                                // released yet this goes straight to TIED.
                                lane_en_q <= lane_dn;
                                abort_q   <= 1'b0;
                                if (lane_dn == '0) begin
                                    state_q   <= ST_TIED;
                                    busy_q    <= 1'b0;
                                    dn_done_q <= 1'b1;
                                end else begin
                                    state_q <= ST_DOWN;
                                end
                            end else begin
                                lane_en_q <= lane_up;
                                if (lane_up[N_LANES-1]) begin
                                    state_q   <= ST_ACTIVE;
                                    busy_q    <= 1'b0;
                                    up_done_q <= 1'b1;
                                end
                            end
                        end else if (dn_req) begin
                            abort_q <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (dn_req) begin
                            state_q <= ST_DOWN;
                            busy_q  <= 1'b1;
                            gap_q   <= cfg_gap;
                        end
                    end
                    ST_DOWN: begin
                        if (cnt_tc) begin
                            lane_en_q <= lane_dn;
                            if (lane_dn == '0) begin
                                state_q   <= ST_TIED;
                                busy_q    <= 1'b0;
                                dn_done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= ST_TIED;
                        lane_en_q <= '0;
                        busy_q    <= 1'b0;
                        abort_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lane_en   = lane_en_q;
    assign busy      = busy_q;
    assign up_done   = up_done_q;
    assign dn_done   = dn_done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/cr_tie_seq.md
CR_TIE_SEQ -- requirements
Module: cr_tie_seq

Interface
REQ-001 Parameter SHALL be N_LANES, default 8, number of tied lane-enable outputs (legal 1..32).
REQ-002 Parameter SHALL be GAP_W, default 8, width of the inter-lane gap count (legal 1..16).
REQ-003 Port SHALL be clk  input  1  single clock; all logic rising-edge.
REQ-004 Port SHALL be rst  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be cfg_gap  input  GAP_W  idle cycles between successive lane transitions; sampled only on request acceptance.
REQ-006 Port SHALL be up_req  input  1  level request to release lanes from tie-low.
REQ-007 Port SHALL be dn_req  input  1  level request to re-tie lanes low.
REQ-008 Port SHALL be lane_en  output  N_LANES  registered lane enables; 0 = tied.
REQ-009 Port SHALL be busy  output  1  high while a sequence is in progress.
REQ-010 Port SHALL be up_done  output  1  one-cycle pulse when the last lane releases.
REQ-011 Port SHALL be dn_done  output  1  one-cycle pulse when lane 0 is re-tied.

Function
REQ-012 FSM states SHALL be TIED, UP, ACTIVE, DOWN; busy = (UP or DOWN), registered.
REQ-013 In TIED, up_req=1 at edge T SHALL accept: latch gap_q=cfg_gap, enter UP; lane k asserts at edge T+1+k*(gap_q+1).
REQ-014 Release order SHALL be lane 0 upward; up_done pulses in the cycle lane N_LANES-1 asserts; the same edge enters ACTIVE.
REQ-015 In ACTIVE, dn_req=1 at edge T SHALL accept: latch gap_q, enter DOWN; lane N_LANES-1-k deasserts at edge T+1+k*(gap_q+1).
REQ-016 dn_done SHALL pulse in the cycle lane 0 deasserts; the same edge enters TIED.
REQ-017 cfg_gap=0 SHALL give one lane transition per cycle; cfg_gap=2^GAP_W-1 SHALL not wrap or shorten.
REQ-018 cfg_gap changes while busy SHALL have no effect.
REQ-019 up_req and dn_req both high in TIED SHALL accept up; dn_req alone in TIED SHALL be ignored (no dn_done).
REQ-020 up_req in ACTIVE or DOWN SHALL be ignored.
REQ-021 dn_req during UP SHALL abort: at the next lane-transition point enter DOWN from the highest asserted lane, using the original gap_q; no up_done.
REQ-022 If the abort point occurs before any lane has asserted, the FSM SHALL return to TIED with a dn_done pulse and lane_en stays 0.
REQ-023 lane_en SHALL only ever be a contiguous low-order mask (bits 0..m set, all others clear).
REQ-024 N_LANES=1 SHALL work: up_done pulses at T+1 with lane 0.

Reset
REQ-025 rst=1 SHALL at the next edge force TIED, lane_en=0, busy=0, up_done=0, dn_done=0, gap counter=0, gap_q=0.
REQ-026 Reset mid-sequence SHALL clear all lanes in one edge with no done pulse.
REQ-027 Requests present in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro CR_TIE_SEQ_FORCE_EN SHALL add input force_tie (1 bit).
REQ-029 With the macro defined, force_tie=1 SHALL at the next edge zero lane_en and enter TIED with no done pulse. It SHALL take priority over requests but not over rst.
REQ-030 Without the macro, the force_tie port SHALL be absent and behaviour SHALL equal force_tie tied 0.

Structure
REQ-031 Package cr_tie_seq_pkg SHALL hold the state enum, default parameter constants, and legal-range limits.
REQ-032 Sub-module cr_tie_seq_gap_cnt SHALL implement the loadable GAP_W down-counter with a terminal-count output.

Verification
REQ-033 N_LANES=8, cfg_gap=3, up_req pulse at T -> lanes 0..7 assert at T+1,5,...,29; up_done at T+29; busy low at T+30.
REQ-034 From ACTIVE, cfg_gap=0, dn_req at T -> lanes 7..0 clear at T+1..T+8; dn_done at T+8; state TIED.
REQ-035 cfg_gap=2, up_req at T, dn_req at T+5 -> lane 1 set at T+4; at T+7 lane 1 clears instead of lane 2 setting; lane 0 clears at T+10 with dn_done; no up_done.
REQ-036 rst asserted at T+6 of REQ-033 run -> lane_en=0 at T+7, no done pulses; then up_req restarts from lane 0.
REQ-037 up_req and dn_req both high in TIED -> UP sequence runs; dn_req alone in TIED -> no activity for 20 cycles.
REQ-038 With CR_TIE_SEQ_FORCE_EN, force_tie at T+10 of REQ-033 -> lane_en=0 at T+11, state TIED, no done pulse.
